// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locking scheduler that shares one 8N1 UART transmit line
// among NUM_REQ byte-stream requesters.
module uart_tx_sched #(
    parameter  int NUM_REQ      = 2,
    parameter  int CLKS_PER_BIT = 868,
    parameter  int DATA_W       = 8,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      locked
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic [DATA_W-1:0] shift_reg, shift_reg_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]   grant_id_nxt;
    logic              locked_nxt;

    logic [NUM_REQ-1:0] valid_rot;
    logic [ID_W-1:0]    cand;
    logic               cand_hit;
    logic               cand_last;
    logic [DATA_W-1:0]  cand_data;
    logic               accept;

    function automatic logic [ID_W-1:0] ptr_add(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum -= NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Candidate selection: a held lock pins the owner, otherwise the first valid
    // requester at or after rr_ptr wins. Scanning from the far end lets the
    // nearest hit overwrite the others without an early exit.
    always_comb begin
        valid_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        cand      = grant_id;
        cand_hit  = 1'b0;
        if (locked) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ID_W'(i) == grant_id) cand_hit = req_valid[i];
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (valid_rot[k]) begin
                    cand_hit = 1'b1;
                    cand     = ptr_add(rr_ptr, k);
                end
            end
        end

        cand_data = '0;
        cand_last = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == cand) begin
                cand_data    = req_data[i*DATA_W +: DATA_W];
                cand_last    = req_last[i];
                req_ready[i] = cand_hit && (state == IDLE) && !rst;
            end
        end
        accept = |req_ready;
    end

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        shift_reg_nxt = shift_reg;
        rr_ptr_nxt    = rr_ptr;
        grant_id_nxt  = grant_id;
        locked_nxt    = locked;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = START;
                    baud_cnt_nxt  = '0;
                    bit_idx_nxt   = '0;
                    shift_reg_nxt = cand_data;
                    grant_id_nxt  = cand;
                    rr_ptr_nxt    = ptr_add(cand, 1);
                    locked_nxt    = ~cand_last;
                end
            end
            START: begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_nxt  = '0;
                    shift_reg_nxt = shift_reg >> 1;
                    bit_idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == BIT_LAST) state_nxt = STOP;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            grant_id <= grant_id_nxt;
            rr_ptr   <= rr_ptr_nxt;
            locked   <= locked_nxt;
        end
    end

    // The shift register is only observed in DATA, so it carries no reset.
    always_ff @(posedge clk) begin
        shift_reg <= shift_reg_nxt;
    end

    assign busy = (state != IDLE);

    always_comb begin
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-timeline model checked every cycle, directed
// scenarios with literal expectations, and uart_rx decoders on both tx pins.
module tb_uart_tx_sched;
    localparam int NR    = 2;
    localparam int CPB   = 4;
    localparam int CPB_D = 868;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]   req_valid, req_last, req_ready;
    logic [NR*8-1:0] req_data;
    logic            tx, busy, locked;
    logic [0:0]      grant_id;

    logic [NR-1:0]   dv, dl, drdy;
    logic [NR*8-1:0] dd;
    logic            dtx, dbusy, dlocked;
    logic [0:0]      dgid;

    uart_tx_sched #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx(tx), .busy(busy),
        .grant_id(grant_id), .locked(locked));

    uart_tx_sched #(.NUM_REQ(NR)) dut_def (
        .clk(clk), .rst(rst), .req_valid(dv), .req_data(dd),
        .req_last(dl), .req_ready(drdy), .tx(dtx), .busy(dbusy),
        .grant_id(dgid), .locked(dlocked));

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int fail_prints = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a frame is a timeline of 10 bit slots of CPB cycles each.
    bit         m_active = 1'b0;
    int         m_el = 0;
    logic [7:0] m_byte = 8'h00;
    int         m_gid = 0;
    int         m_rr = 0;
    bit         m_locked = 1'b0;
    int         m_c, m_c2, m_ph;

    function automatic int m_cand();
        if (m_locked) return (1'(req_valid >> m_gid)) ? m_gid : -1;
        for (int k = 0; k < NR; k++) begin
            if (1'(req_valid >> ((m_rr + k) % NR))) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_n++;
        if (rst) begin
            m_active = 1'b0; m_el = 0; m_gid = 0; m_rr = 0; m_locked = 1'b0;
        end else if (m_active) begin
            m_el++;
            if (m_el == FRAME) m_active = 1'b0;
        end else begin
            m_c = m_cand();
            if (m_c >= 0) begin
                m_active = 1'b1;
                m_el     = 0;
                m_byte   = 8'(req_data >> (m_c * 8));
                m_gid    = m_c;
                m_rr     = (m_c + 1) % NR;
                m_locked = !(1'(req_last >> m_c));
            end
        end
    end

    logic          e_tx, e_busy, e_lk;
    logic [NR-1:0] e_rdy;
    logic [0:0]    e_gid;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_rdy = '0;
            if (!rst && !m_active) begin
                m_c2 = m_cand();
                if (m_c2 >= 0) e_rdy = NR'(1) << m_c2;
            end
            m_ph = m_el / CPB;
            if (!m_active)     e_tx = 1'b1;
            else if (m_ph == 0) e_tx = 1'b0;
            else if (m_ph <= 8) e_tx = 1'(m_byte >> (m_ph - 1));
            else               e_tx = 1'b1;
            e_busy = m_active;
            e_gid  = 1'(m_gid);
            e_lk   = m_locked;
            checks++;
            if (tx !== e_tx || busy !== e_busy || req_ready !== e_rdy ||
                grant_id !== e_gid || locked !== e_lk) begin
                failures++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL cycle%0d: got tx=%b busy=%b rdy=%b gid=%0d lk=%b expected tx=%b busy=%b rdy=%b gid=%0d lk=%b",
                             cyc_n, tx, busy, req_ready, grant_id, locked,
                             e_tx, e_busy, e_rdy, e_gid, e_lk);
                end
            end
        end
    end

    // uart_rx decoders: detect start, sample mid-bit, keep frames with a valid stop.
    int    rxq_s[$];
    string rx_str = "";

    initial forever begin
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            logic [7:0] b;
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                b[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx === 1'b1) rxq_s.push_back(int'(b));
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && dtx === 1'b0) begin
            logic [7:0] b;
            repeat (CPB_D / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB_D) @(negedge clk);
                b[k] = dtx;
            end
            repeat (CPB_D) @(negedge clk);
            if (dtx === 1'b1) rx_str = $sformatf("%s%c", rx_str, b);
        end
    end

    function automatic int qget(input int k);
        if (k < rxq_s.size()) return rxq_s[k];
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        for (int k = 0; k < NR; k++) begin
            if (k == i) begin
                req_valid[k]      = v;
                req_data[k*8 +: 8] = d;
                req_last[k]       = l;
            end
        end
    endtask

    // Waits for a ready pulse, then steps past the accept edge.
    task automatic wait_any(input bit use_def, input int budget, output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int n = 0; n < budget && idx < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) begin
                if (use_def ? drdy[k] : req_ready[k]) idx = k;
            end
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_accept: got no ready expected one within %0d cycles", budget);
        end else begin
            at = cyc_n;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, at, at_prev, bad, busy_cnt;
        logic [9:0] t1_pat;
        logic [7:0] msg [3];
        req_valid = '0; req_data = '0; req_last = '0;
        dv = '0; dd = '0; dl = '0;
        rst = 1'b1;
        at_prev = 0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_gid", int'(grant_id), 0);
        chk("reset_ready", int'(req_ready), 0);
        chk("reset_tx_def", int'(dtx), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte 0x41
        t1_pat = 10'b10_1000_0010;
        set_req(0, 1'b1, 8'h41, 1'b1);
        wait_any(1'b0, 10, idx, at);
        chk("t1_grant", idx, 0);
        set_req(0, 1'b0, 8'h00, 1'b0);
        bad = 0;
        busy_cnt = 0;
        for (int p = 0; p < 10; p++) begin
            for (int q = 0; q < CPB; q++) begin
                @(negedge clk);
                if (tx !== t1_pat[p]) bad++;
                if (busy) busy_cnt++;
            end
        end
        @(negedge clk);
        if (busy) busy_cnt++;
        chk("t1_tx_pattern_errors", bad, 0);
        chk("t1_busy_cycles", busy_cnt, 40);
        chk("t1_locked", int'(locked), 0);
        repeat (2) @(negedge clk);
        chk("t1_rx_count", rxq_s.size(), 1);
        chk("t1_rx_byte", qget(0), 32'h41);

        // Round-robin from a fresh pointer
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        rxq_s.delete();
        set_req(0, 1'b1, 8'hA0, 1'b1);
        set_req(1, 1'b1, 8'hB1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            wait_any(1'b0, 60, idx, at);
            chk($sformatf("t2_grant%0d", n), idx, n % 2);
            if (n > 0) chk($sformatf("t2_spacing%0d", n), at - at_prev, 41);
            at_prev = at;
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (FRAME + 5) @(posedge clk);
        #1;
        chk("t2_rx_count", rxq_s.size(), 4);
        chk("t2_rx0", qget(0), 32'hA0);
        chk("t2_rx1", qget(1), 32'hB1);
        chk("t2_rx2", qget(2), 32'hA0);
        chk("t2_rx3", qget(3), 32'hB1);

        // Packet lock: 'H','I' from req0 while req1 waits with 0x0A
        rxq_s.delete();
        set_req(1, 1'b1, 8'h0A, 1'b1);
        set_req(0, 1'b1, 8'h48, 1'b0);
        wait_any(1'b0, 5, idx, at);
        chk("t3_first", idx, 0);
        set_req(0, 1'b1, 8'h49, 1'b1);
        @(negedge clk);
        chk("t3_locked_after_H", int'(locked), 1);
        wait_any(1'b0, 60, idx, at);
        chk("t3_second", idx, 0);
        set_req(0, 1'b0, 8'h00, 1'b0);
        at_prev = at;
        @(negedge clk);
        chk("t3_locked_after_I", int'(locked), 0);
        wait_any(1'b0, 60, idx, at);
        chk("t3_third", idx, 1);
        chk("t3_stall_gap", at - at_prev, 41);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (FRAME + 5) @(posedge clk);
        #1;
        chk("t3_rx_count", rxq_s.size(), 3);
        chk("t3_rx0", qget(0), 32'h48);
        chk("t3_rx1", qget(1), 32'h49);
        chk("t3_rx2", qget(2), 32'h0A);

        // Reset during DATA bit 3 of a locking byte
        set_req(0, 1'b1, 8'h55, 1'b0);
        wait_any(1'b0, 5, idx, at);
        chk("t4_grant", idx, 0);
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy_before", int'(busy), 1);
        chk("t4_locked_before", int'(locked), 1);
        @(negedge clk);
        chk("t4_tx_after", int'(tx), 1);
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_locked_after", int'(locked), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(1, 1'b1, 8'h3C, 1'b1);
        wait_any(1'b0, 5, idx, at);
        chk("t4_req1_granted", idx, 1);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (FRAME + 100) @(posedge clk);
        #1;
        rxq_s.delete();

        // req1 raises valid mid-frame and is taken on the first IDLE cycle
        set_req(0, 1'b1, 8'h12, 1'b1);
        wait_any(1'b0, 5, idx, at);
        chk("t5_first", idx, 0);
        at_prev = at;
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        set_req(1, 1'b1, 8'h34, 1'b1);
        wait_any(1'b0, 60, idx, at);
        chk("t5_second", idx, 1);
        chk("t5_gap", at - at_prev, 41);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (FRAME + 5) @(posedge clk);
        #1;
        chk("t5_rx_count", rxq_s.size(), 2);
        chk("t5_rx0", qget(0), 32'h12);
        chk("t5_rx1", qget(1), 32'h34);

        // Default baud: "OK\n"
        msg[0] = 8'h4F;
        msg[1] = 8'h4B;
        msg[2] = 8'h0A;
        for (int n = 0; n < 3; n++) begin
            dv[0] = 1'b1;
            dd[7:0] = msg[n];
            dl[0] = 1'b1;
            wait_any(1'b1, 10 * CPB_D + 20, idx, at);
            chk($sformatf("t6_grant%0d", n), idx, 0);
            dv[0] = 1'b0;
        end
        repeat (10 * CPB_D + 10) @(posedge clk);
        #1;
        $display("uart_rx decoded: \"%s\"", rx_str);
        chk("t6_rx_len", rx_str.len(), 3);
        chk("t6_rx_text", (rx_str == "OK\n") ? 1 : 0, 1);
        chk("t6_busy_idle", int'(dbusy), 0);
        chk("t6_locked", int'(dlocked), 0);
        chk("t6_gid", int'(dgid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
